// File: rtl/pdm_fir_mac.sv
// pdm_fir_mac: 16-tap serial multiply-accumulate FIR for the PDM capture path
// One tap is processed per cycle, against an external coefficient ROM with 1-cycle latency.
// Ports:
//   clk, rst_n (async active-low)
//   in_data/in_valid/in_ready : PCM sample input handshake (ready only in IDLE)
//   cidx -> ROM index, coef <- registered ROM data
//   out_data/out_valid        : filtered sample, one-cycle pulse
// Param SHIFT: arithmetic right shift of the accumulator before narrowing (0..20)
// Define PDM_FIR_SAT_EN to saturate when narrowing; otherwise the result wraps.
module pdm_fir_mac #(
  parameter int SHIFT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic        [3:0]  cidx,
  input  logic signed [15:0] coef,
  output logic signed [15:0] out_data,
  output logic               out_valid
);
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state, state_nx;
  logic signed [15:0] tap [16];
  logic        [4:0]  cnt;
  logic        [3:0]  tidx;
  logic               last;
  logic signed [31:0] prod;
  logic signed [35:0] acc, sum;
  logic signed [15:0] nar;
  assign last     = cnt == 5'd16;
  assign in_ready = state == IDLE;
  assign cidx     = state != MAC ? 4'd0 : cnt[4] ? 4'd15 : cnt[3:0];
  // coef arriving at cnt pairs with tap[cnt-1]; at cnt = 16 this wraps to tap[15]
  assign tidx = cnt[3:0] - 4'd1;
  assign prod = 32'(coef) * 32'(tap[tidx]);
  assign sum  = acc + 36'(prod);
`ifdef PDM_FIR_SAT_EN
  logic signed [35:0] r;
  assign r   = sum >>> SHIFT;
  assign nar = r > 36'sd32767 ? 16'sh7fff : r < -36'sd32768 ? 16'sh8000 : r[15:0];
`else
  assign nar = 16'(sum >>> SHIFT);
`endif
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (in_valid ? MAC : IDLE) : state == MAC ? (last ? DONE : MAC) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < 16; i++) tap[i] <= '0;
    end else begin
      state     <= state_nx;
      out_valid <= 1'b0;
      if (state == IDLE && in_valid) begin
        for (int i = 15; i > 0; i--) tap[i] <= tap[i-1];
        tap[0] <= in_data;
        acc    <= '0;
        cnt    <= '0;
      end
      if (state == MAC) begin
        cnt <= last ? cnt : cnt + 5'd1;
        if (cnt != 5'd0) acc <= sum;
        if (last) begin
          out_data  <= nar;
          out_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pdm_fir_mac.sv
// tb_pdm_fir_mac: randomized cycle-exact bench for pdm_fir_mac against a direct-form FIR model
module tb_pdm_fir_mac;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic signed [15:0] coef0 = '0, coef1 = '0, out_data0, out_data1;
  logic [3:0] cidx0, cidx1;
  logic in_ready0, in_ready1, out_valid0, out_valid1;
  logic signed [15:0] rom [16];
  longint hist [16];
  logic signed [15:0] sq[$];
  logic signed [15:0] olog[$];
  logic signed [15:0] last0, last1;
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  pdm_fir_mac #(.SHIFT(0)) dut0 (.clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .cidx(cidx0), .coef(coef0), .out_data(out_data0), .out_valid(out_valid0));
  pdm_fir_mac #(.SHIFT(2)) dut1 (.clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .cidx(cidx1), .coef(coef1), .out_data(out_data1), .out_valid(out_valid1));

  always @(posedge clk) begin
    coef0 <= rom[cidx0];
    coef1 <= rom[cidx1];
  end

  function automatic logic signed [15:0] narrow(input longint r);
`ifdef PDM_FIR_SAT_EN
    return r > 32767 ? 16'sh7fff : r < -32768 ? 16'sh8000 : 16'(r);
`else
    return 16'(r);
`endif
  endfunction

  function automatic longint fir();
    longint a = 0;
    for (int k = 0; k < 16; k++) a += longint'(rom[k]) * hist[k];
    return a;
  endfunction

  task automatic set_rom_default();
    int t [16] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0};
    for (int k = 0; k < 16; k++) rom[k] = 16'(t[k]);
  endtask

  task automatic clear_hist();
    for (int k = 0; k < 16; k++) hist[k] = 0;
  endtask

  task automatic fill(input int n, input logic signed [15:0] v);
    sq.delete();
    repeat (n) sq.push_back(v);
  endtask

  // Feeds sq sample by sample with in_valid held high except during optional idle gaps,
  // scrambling in_data on every non-accept cycle, and checks every cycle of each 19-cycle frame.
  task automatic stream(input int max_gap);
    olog.delete();
    foreach (sq[i]) begin
      int g;
      longint a;
      logic signed [15:0] e0, e1;
      g = max_gap > 0 ? int'($urandom_range(0, max_gap)) : 0;
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        checks++;
        if (in_ready0 !== 1'b1 || cidx0 !== 4'd0 || out_valid0 !== 1'b0)
          $display("FAIL idle_gap got rdy=%0b cidx=%0d ov=%0b exp rdy=1 cidx=0 ov=0", in_ready0, cidx0, out_valid0);
        else passed++;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = sq[i];
      for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = longint'(sq[i]);
      a  = fir();
      e0 = narrow(a);
      e1 = narrow(a >>> 2);
      for (int p = 0; p < 19; p++) begin
        logic [3:0] ec;
        ec = (p == 0 || p == 18) ? 4'd0 : (p - 1 > 15) ? 4'd15 : 4'(p - 1);
        if (p > 0) in_data = 16'($urandom);
        checks++;
        if (in_ready0 !== (p == 0) || in_ready1 !== (p == 0))
          $display("FAIL in_ready p=%0d got %0b/%0b exp %0b", p, in_ready0, in_ready1, p == 0);
        else passed++;
        checks++;
        if (cidx0 !== ec) $display("FAIL cidx p=%0d got %0d exp %0d", p, cidx0, ec);
        else passed++;
        checks++;
        if (out_valid0 !== (p == 18) || out_valid1 !== (p == 18))
          $display("FAIL out_valid p=%0d got %0b/%0b exp %0b", p, out_valid0, out_valid1, p == 18);
        else passed++;
        if (p == 18) begin
          checks++;
          if (out_data0 !== e0) $display("FAIL out_data sample=%0d got %0d exp %0d", i, out_data0, e0);
          else passed++;
          checks++;
          if (out_data1 !== e1) $display("FAIL out_data_shift2 sample=%0d got %0d exp %0d", i, out_data1, e1);
          else passed++;
          olog.push_back(out_data0);
          last0 = out_data0;
          last1 = out_data1;
        end
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_data0 !== 16'sd0 || out_valid0 !== 1'b0 || cidx0 !== 4'd0 || in_ready0 !== 1'b1)
      $display("FAIL reset got od=%0d ov=%0b cidx=%0d rdy=%0b exp 0/0/0/1", out_data0, out_valid0, cidx0, in_ready0);
    else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    int exp_imp [16] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0};
    fill(16, 16'sd0);
    sq[0] = 16'sd1;
    stream(0);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (olog.size() != 16 || olog[k] !== 16'(exp_imp[k]))
        $display("FAIL impulse k=%0d got %0d exp %0d", k, olog.size() == 16 ? olog[k] : 16'sd0, exp_imp[k]);
      else passed++;
    end
  endtask

  task automatic test_step();
    fill(10, 16'sd1000);
    stream(3);
    checks++;
    if (last0 !== 16'sd25000) $display("FAIL step1000 got %0d exp 25000", last0);
    else passed++;
    checks++;
    if (last1 !== 16'sd6250) $display("FAIL step1000_shift2 got %0d exp 6250", last1);
    else passed++;
  endtask

  task automatic test_overflow();
    fill(10, 16'sd2000);
    stream(1);
    checks++;
`ifdef PDM_FIR_SAT_EN
    if (last0 !== 16'sd32767) $display("FAIL step2000 got %0d exp 32767", last0);
`else
    if (last0 !== -16'sd15536) $display("FAIL step2000 got %0d exp -15536", last0);
`endif
    else passed++;
    fill(10, -16'sd2000);
    stream(1);
    checks++;
`ifdef PDM_FIR_SAT_EN
    if (last0 !== -16'sd32768) $display("FAIL step_neg2000 got %0d exp -32768", last0);
`else
    if (last0 !== 16'sd15536) $display("FAIL step_neg2000 got %0d exp 15536", last0);
`endif
    else passed++;
  endtask

  task automatic test_reset_mid_mac();
    int nv = 0;
    fill(9, 16'sd1000);
    stream(0);
    in_valid = 1'b1;
    in_data  = 16'sd1000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (cidx0 !== 4'd7) $display("FAIL mid_mac_cidx got %0d exp 7", cidx0);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_data0 !== 16'sd0 || out_valid0 !== 1'b0 || cidx0 !== 4'd0 || in_ready0 !== 1'b1)
      $display("FAIL mid_mac_reset got od=%0d ov=%0b cidx=%0d rdy=%0b exp 0/0/0/1", out_data0, out_valid0, cidx0, in_ready0);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_hist();
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid0 || out_valid1) nv++;
    end
    checks++;
    if (nv != 0) $display("FAIL aborted_pulse got %0d pulses exp 0", nv);
    else passed++;
    fill(1, 16'sd1);
    stream(0);
    checks++;
    if (last0 !== 16'sd1) $display("FAIL post_reset_impulse got %0d exp 1", last0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    sq.delete();
    repeat (6) sq.push_back(16'($urandom));
    stream(0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) rom[k] = 16'($urandom);
    sq.delete();
    repeat (20) sq.push_back(16'($urandom));
    stream(4);
  endtask

  initial begin
    set_rom_default();
    clear_hist();
    test_reset();
    test_impulse();
    test_step();
    test_overflow();
    test_reset_mid_mac();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pdm_fir_mac.md
# pdm_fir_mac

Serial multiply-accumulate FIR engine for the PDM capture path. Accepts 16-bit signed PCM samples from the upstream PDM-to-PCM stage and keeps a 16-entry delay line. For each sample it walks all 16 taps by driving the coefficient ROM index (`cidx`) and consuming the returned `coef` one cycle later. It emits one filtered 16-bit sample per accepted input.

## Interface
- `SHIFT`, default 0: arithmetic right shift applied to the final accumulator before narrowing to 16 bits; legal range 0..20.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in 16: signed input sample.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: block can accept a sample; high only in IDLE.
- `cidx` out 4: coefficient ROM index.
- `coef` in 16: signed coefficient; ROM returns `coef[cidx]` registered, with 1-cycle latency.
- `out_data` out 16: signed filtered sample.
- `out_valid` out 1: one-cycle pulse; `out_data` is valid while it is high.

## Operation
- State machine:
  - IDLE → MAC when `in_valid & in_ready`.
  - MAC → DONE when `cnt == 16`.
  - DONE → IDLE unconditionally.
- Accept (IDLE with handshake):
  - Delay line shifts: `tap[k] <= tap[k-1]` for k = 15..1, `tap[0] <= in_data`.
  - Accumulator cleared to 0; `cnt <= 0`.
- MAC state:
  - 5-bit counter `cnt` runs 0..16.
  - `cidx = cnt[3:0]` for cnt 0..15; `cidx` is held at 15 when cnt = 16.
  - For cnt ≥ 1: `acc += coef * tap[cnt-1]`.
  - Product is 16x16 signed → 32 bits. Accumulator is 36-bit signed, so 16 products cannot overflow.
- Narrowing:
  - At cnt == 16, form `r = (acc + last product) >>> SHIFT`, arithmetic.
  - Register `out_data <= narrow(r)` and `out_valid <= 1`.
- DONE state: `out_valid` high for exactly this cycle; cleared on the next edge.
- `in_valid` outside IDLE is ignored; the upstream stage holds data until `in_ready` rises.
- `cidx` is 0 in IDLE and DONE.
- Reset values:
  - `out_data` = 0, `out_valid` = 0, `cidx` = 0, `in_ready` = 1 (state IDLE).
  - All delay-line taps = 0, accumulator = 0, `cnt` = 0.
- Reset asserted mid-MAC or in DONE:
  - Computation aborts with no `out_valid` pulse.
  - Delay line is cleared, so history is lost.

## Timing
- Handshake at edge T (IDLE) → MAC during T+1..T+17 → DONE with `out_valid` high during T+18 → IDLE at T+19.
- Latency: accept edge to `out_valid` cycle = 18 cycles.
- Throughput: one sample per 19 cycles; `in_ready` is low for 18 cycles after each accept.
- Coefficient for `cidx = k` is presented during cycle T+1+k and consumed during T+2+k.
- The counter-to-tap mapping above absorbs the ROM latency. No extra drain beyond cnt = 16.
- A back-to-back sample held on `in_valid` is accepted at the first IDLE edge, T+19.

## Configuration
- `PDM_FIR_SAT_EN` defined:
  - `narrow` saturates: r > 32767 → 32767; r < −32768 → −32768; otherwise `r[15:0]`.
- `PDM_FIR_SAT_EN` undefined:
  - `narrow` is plain truncation to `r[15:0]` (two's-complement wrap).
  - No comparators are instantiated.

## Test plan
All scenarios use the ROM table 1,2,3,4,5,4,3,2,1,0,0,0,0,0,0,0 and SHIFT = 0 unless stated.
- **Impulse:** reset, then feed 1 followed by fifteen 0s → outputs 1,2,3,4,5,4,3,2,1,0,0,0,0,0,0,0.
- **Step 1000:** feed 1000 repeatedly → after 9 samples, `out_data` = 25000 steady. Each `out_valid` arrives exactly 18 cycles after its accept edge; `in_ready` is low 18 cycles per sample.
- **Overflow:** step 2000 → with `PDM_FIR_SAT_EN`, steady 32767; without it, −15536. Step −2000 → −32768 saturated, 15536 wrapped.
- **SHIFT = 2, step 1000:** steady output 6250.
- **Reset mid-MAC:** assert `rst_n` low at cnt = 7 of a 1000-sample computation → no `out_valid`, all outputs 0, `in_ready` = 1. Next impulse of 1 yields 1 (history cleared).
- **Handshake abuse:** hold `in_valid` high with changing data during MAC/DONE → only values present at IDLE edges are accepted. Exactly one `out_valid` per accept; `cidx` sequence 0..15 then 15 per accept, 0 when idle.
